// File: rtl/jailbreak_audio_decim.sv
// -----------------------------------------------------------------------------
// jailbreak_audio_decim
//
// Final audio stage of the Jailbreak board model. Every clk_49m cycle the raw
// SN76489 level and the VLM5030 level are centred, scaled and summed. The sum
// is boxcar-averaged over DIV cycles, saturated to 16 bits, scaled by a
// pause mute/unmute volume ramp and handed to the audio output path through a
// valid/ready handshake.
//
// Parameters:
//   DIV          decimation length in clk_49m cycles (power of two, 2..4096)
//   PSG_SHIFT    left shift applied to the centred PSG level
//   SPEECH_SHIFT left shift applied to the speech level
//
// Ports:
//   clk_49m      system clock, 49.152 MHz
//   reset        synchronous, active-high reset
//   psg_in       unsigned PSG level, 128 = silence
//   speech_in    signed speech level
//   pause        1 = ramp the output down to silence, 0 = ramp back up
//   sample_out   signed averaged sample
//   sample_valid sample_out holds an unconsumed sample
//   sample_ready consumer accepts sample_out when sample_valid && sample_ready
//   overrun      sticky: an unconsumed sample was overwritten
// -----------------------------------------------------------------------------
module jailbreak_audio_decim #(
   parameter int unsigned DIV          = 1024,
   parameter int unsigned PSG_SHIFT    = 5,
   parameter int unsigned SPEECH_SHIFT = 4
) (
   input  logic        clk_49m,
   input  logic        reset,
   input  logic [7:0]  psg_in,
   input  logic [9:0]  speech_in,
   input  logic        pause,
   output logic [15:0] sample_out,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        overrun
);

   localparam int unsigned DIV_LOG2 = $clog2(DIV);
   localparam int unsigned ACC_W    = 18 + DIV_LOG2;

   localparam logic [DIV_LOG2-1:0] CNT_MAX  = DIV_LOG2'(DIV - 1);
   localparam logic [4:0]          VOL_FULL = 5'd16;

   // ---------------------------------------------------------------------------
   // Per-cycle mix
   // ---------------------------------------------------------------------------
   logic signed [8:0]       psg_c;
   logic signed [17:0]      psg_ext;
   logic signed [17:0]      speech_ext;
   logic signed [17:0]      mix;
   logic signed [ACC_W-1:0] mix_ext;

   always_comb begin
      psg_c      = $signed({1'b0, psg_in}) - 9'sd128;
      psg_ext    = $signed({{9{psg_c[8]}}, psg_c});
      speech_ext = $signed({{8{speech_in[9]}}, speech_in});
      // Worst case with the widest supported shifts still fits 18 bits, so no
      // clipping is needed before accumulation.
      mix        = (psg_ext <<< PSG_SHIFT) + (speech_ext <<< SPEECH_SHIFT);
      mix_ext    = $signed({{DIV_LOG2{mix[17]}}, mix});
   end

   // ---------------------------------------------------------------------------
   // Window counter and accumulator
   // ---------------------------------------------------------------------------
   logic [DIV_LOG2-1:0]     cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] avg;
   logic signed [15:0]      avg_sat;
   logic                    boundary;
   logic                    avg_fits;

   always_comb begin
      boundary = (cnt_q == CNT_MAX);
      cnt_d    = cnt_q + DIV_LOG2'(1);
      // The boundary cycle's own mix is part of the window it closes.
      acc_sum  = acc_q + mix_ext;
      acc_d    = boundary ? '0 : acc_sum;
      // Arithmetic shift truncates toward -inf.
      avg      = acc_sum >>> DIV_LOG2;
   end

   // avg fits in 16 bits exactly when every bit from 15 upward matches.
   always_comb begin
      avg_fits = (&avg[ACC_W-1:15]) || !(|avg[ACC_W-1:15]);
      if (avg_fits) begin
         avg_sat = avg[15:0];
      end else if (avg[ACC_W-1]) begin
         avg_sat = 16'sh8000;
      end else begin
         avg_sat = 16'sh7fff;
      end
   end

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Volume ramp (0..16), stepped once per boundary
   // ---------------------------------------------------------------------------
   logic [4:0] vol_q, vol_d;

   always_comb begin
      vol_d = vol_q;
      if (boundary) begin
         if (pause && (vol_q != 5'd0)) begin
            vol_d = vol_q - 5'd1;
         end else if (!pause && (vol_q != VOL_FULL)) begin
            vol_d = vol_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         vol_q <= VOL_FULL;
      end else begin
         vol_q <= vol_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: saturated average plus the volume in force when it was captured
   // ---------------------------------------------------------------------------
   logic signed [15:0] s1_q;
   logic [4:0]         vol_used_q;
   logic               s2_go_q;

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         s1_q       <= '0;
         vol_used_q <= VOL_FULL;
         s2_go_q    <= 1'b0;
      end else begin
         s2_go_q <= boundary;
         if (boundary) begin
            s1_q       <= avg_sat;
            // Stage 2 runs a cycle later, after vol has stepped; keep the
            // pre-step value so the ramp starts from the current level.
            vol_used_q <= vol_q;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: volume scaling
   // ---------------------------------------------------------------------------
   logic signed [21:0] s1_ext;
   logic signed [21:0] vol_ext;
   logic signed [21:0] prod;
   logic signed [15:0] scaled;

   always_comb begin
      s1_ext  = $signed({{6{s1_q[15]}}, s1_q});
      vol_ext = $signed({17'd0, vol_used_q});
      prod    = s1_ext * vol_ext;
      // |s1*vol| <= 2^19, so after the shift the result always fits 16 bits.
      scaled  = 16'(prod >>> 4);
   end

   // ---------------------------------------------------------------------------
   // Output register and handshake
   // ---------------------------------------------------------------------------
   logic [15:0] sample_out_d;
   logic        sample_valid_d;
   logic        overrun_d;

   always_comb begin
      sample_out_d   = sample_out;
      sample_valid_d = sample_valid;
      overrun_d      = overrun;
      if (s2_go_q) begin
         // A fresh sample always wins; it is only lost data if the old one
         // was still pending and not being taken this cycle.
         sample_out_d   = scaled;
         sample_valid_d = 1'b1;
         if (sample_valid && !sample_ready) begin
            overrun_d = 1'b1;
         end
      end else if (sample_valid && sample_ready) begin
         sample_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         sample_out   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_out   <= sample_out_d;
         sample_valid <= sample_valid_d;
         overrun      <= overrun_d;
      end
   end

endmodule

// File: tb/tb_jailbreak_audio_decim.sv
// -----------------------------------------------------------------------------
// tb_jailbreak_audio_decim
//
// Directed bench for jailbreak_audio_decim. A default build (DIV=1024) covers
// silence timing, full-scale and negative levels, the pause ramp, the
// handshake and mid-window reset. A second small build (DIV=16, shifts 8/7)
// covers saturation and averaging of a toggling input.
// -----------------------------------------------------------------------------
module tb_jailbreak_audio_decim;

   logic clk_49m = 1'b0;
   always #10 clk_49m = ~clk_49m;

   // Default build
   logic        reset;
   logic [7:0]  psg_in;
   logic [9:0]  speech_in;
   logic        pause;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        sample_ready;
   logic        overrun;

   // Saturation build
   logic        reset2;
   logic [7:0]  psg2;
   logic [9:0]  speech2;
   logic        pause2;
   logic [15:0] out2;
   logic        valid2;
   logic        ready2;
   logic        overrun2;

   jailbreak_audio_decim dut (
      .clk_49m      (clk_49m),
      .reset        (reset),
      .psg_in       (psg_in),
      .speech_in    (speech_in),
      .pause        (pause),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun)
   );

   jailbreak_audio_decim #(
      .DIV          (16),
      .PSG_SHIFT    (8),
      .SPEECH_SHIFT (7)
   ) dut_sat (
      .clk_49m      (clk_49m),
      .reset        (reset2),
      .psg_in       (psg2),
      .speech_in    (speech2),
      .pause        (pause2),
      .sample_out   (out2),
      .sample_valid (valid2),
      .sample_ready (ready2),
      .overrun      (overrun2)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Waits for sample_valid on the default build, sampling on negedges.
   // cycles = number of posedges stepped through until valid was seen.
   task automatic wait_sample(input string tag, output int val, output int cycles);
      val    = 0;
      cycles = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk_49m);
         cycles++;
         @(negedge clk_49m);
         if (sample_valid) begin
            val = int'($signed(sample_out));
            return;
         end
      end
      check_val({tag, "_timeout"}, cycles, 0);
   endtask

   // Same for the saturation build; optionally toggles psg2 0/255 every cycle.
   task automatic wait_sample2(input string tag, input bit toggle, output int val);
      val = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk_49m);
         @(negedge clk_49m);
         if (toggle) psg2 = (psg2 == 8'd0) ? 8'd255 : 8'd0;
         if (valid2) begin
            val = int'($signed(out2));
            return;
         end
      end
      check_val({tag, "_timeout"}, i_timeout_marker(), 0);
   endtask

   function automatic int i_timeout_marker();
      return 200;
   endfunction

   int v;
   int c;
   int vol_m;

   initial begin
      reset        = 1'b1;
      reset2       = 1'b1;
      psg_in       = 8'd128;
      speech_in    = 10'd0;
      pause        = 1'b0;
      sample_ready = 1'b1;
      psg2         = 8'd128;
      speech2      = 10'd0;
      pause2       = 1'b0;
      ready2       = 1'b1;
      repeat (3) @(posedge clk_49m);
      @(negedge clk_49m);

      // Reset state of the default build (held in reset meanwhile)
      check_val("rst_valid",   int'(sample_valid), 0);
      check_val("rst_overrun", int'(overrun), 0);
      check_val("rst_out",     int'($signed(sample_out)), 0);

      // ---- Saturation build: 32512 + 65408 = 97920 -> clamps to 32767
      reset2  = 1'b0;
      psg2    = 8'd255;
      speech2 = 10'd511;
      wait_sample2("sat0", 1'b0, v);
      wait_sample2("sat1", 1'b0, v);
      check_val("sat_a", v, 32767);
      wait_sample2("sat2", 1'b0, v);
      check_val("sat_b", v, 32767);

      // Alternating -32768 / +32512 averages to -128
      speech2 = 10'd0;
      psg2    = 8'd0;
      wait_sample2("tog0", 1'b1, v);
      wait_sample2("tog1", 1'b1, v);
      check_val("toggle_a", v, -128);
      wait_sample2("tog2", 1'b1, v);
      check_val("toggle_b", v, -128);

      // ---- Default build: silence and first-sample latency
      reset = 1'b0;
      wait_sample("sil0", v, c);
      check_val("silence_first_cycle", c, 1025);
      check_val("silence_first_val", v, 0);
      wait_sample("sil1", v, c);
      check_val("silence_period", c, 1024);
      check_val("silence_second_val", v, 0);

      // ---- Full-scale PSG: 127 << 5 = 4064
      psg_in = 8'd255;
      wait_sample("fs_discard", v, c);
      wait_sample("fs0", v, c);
      check_val("fullscale_a", v, 4064);
      wait_sample("fs1", v, c);
      check_val("fullscale_b", v, 4064);

      // ---- Pause ramp: sample uses vol before the step, then vol moves by 1
      vol_m = 16;
      pause = 1'b1;
      for (int k = 0; k < 18; k++) begin
         wait_sample("mute", v, c);
         check_val($sformatf("mute_%0d", k), v, (4064 * vol_m) / 16);
         if (vol_m > 0) vol_m--;
      end
      pause = 1'b0;
      for (int k = 0; k < 18; k++) begin
         wait_sample("unmute", v, c);
         check_val($sformatf("unmute_%0d", k), v, (4064 * vol_m) / 16);
         if (vol_m < 16) vol_m++;
      end

      // ---- Ready asserted in the same cycle a new sample lands: no overrun
      @(posedge clk_49m);
      @(negedge clk_49m);
      sample_ready = 1'b0;
      check_val("hs_idle_valid", int'(sample_valid), 0);
      wait_sample("hs_a", v, c);
      check_val("hs_a_val", v, 4064);
      repeat (1023) @(posedge clk_49m);
      @(negedge clk_49m);
      check_val("hs_stall_valid", int'(sample_valid), 1);
      sample_ready = 1'b1;
      @(posedge clk_49m);
      @(negedge clk_49m);
      check_val("hs_same_valid",   int'(sample_valid), 1);
      check_val("hs_same_overrun", int'(overrun), 0);
      check_val("hs_same_val",     int'($signed(sample_out)), 4064);
      @(posedge clk_49m);
      @(negedge clk_49m);
      check_val("hs_consumed_valid", int'(sample_valid), 0);

      // ---- Stall across two boundaries: second sample overwrites, overrun set.
      // pause during the first boundary makes the second sample distinct (vol 15).
      sample_ready = 1'b0;
      pause        = 1'b1;
      wait_sample("ov_a", v, c);
      pause = 1'b0;
      check_val("ov_first_val", v, 4064);
      repeat (500) @(posedge clk_49m);
      @(negedge clk_49m);
      check_val("ov_hold_val",     int'($signed(sample_out)), 4064);
      check_val("ov_hold_valid",   int'(sample_valid), 1);
      check_val("ov_hold_overrun", int'(overrun), 0);
      repeat (524) @(posedge clk_49m);
      @(negedge clk_49m);
      check_val("ov_second_val",   int'($signed(sample_out)), 3810);
      check_val("ov_second_valid", int'(sample_valid), 1);
      check_val("ov_overrun",      int'(overrun), 1);

      // ---- Reset at cnt=500 with a pending sample and overrun set
      repeat (499) @(posedge clk_49m);
      @(negedge clk_49m);
      reset        = 1'b1;
      sample_ready = 1'b1;
      psg_in       = 8'd0;
      speech_in    = 10'h200;
      @(posedge clk_49m);
      @(negedge clk_49m);
      reset = 1'b0;
      check_val("mid_rst_valid",   int'(sample_valid), 0);
      check_val("mid_rst_overrun", int'(overrun), 0);
      check_val("mid_rst_out",     int'($signed(sample_out)), 0);
      wait_sample("post_rst", v, c);
      check_val("post_rst_cycle", c, 1025);
      check_val("post_rst_val", v, -12288);
      wait_sample("neg1", v, c);
      check_val("negative_val", v, -12288);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
